// File: rtl/exe_unit_rr_sched.sv
// Round-robin arbiter sharing one registered ALU between two requesters.
// Three-state issue/capture sequence; all outputs registered.
module exe_unit_rr_sched #(
    parameter int BITS = 4,
    parameter int N    = 2
) (
    input  logic            i_clk,
    input  logic            i_rsn,
    input  logic [1:0]      i_req,
    input  logic [BITS-1:0] i_argA0,
    input  logic [BITS-1:0] i_argB0,
    input  logic [N-1:0]    i_oper0,
    input  logic [BITS-1:0] i_argA1,
    input  logic [BITS-1:0] i_argB1,
    input  logic [N-1:0]    i_oper1,
    output logic [1:0]      o_ack,
    output logic [BITS-1:0] o_result0,
    output logic [BITS-1:0] o_result1,
    output logic [3:0]      o_status0,
    output logic [3:0]      o_status1,
    output logic [1:0]      o_gnt,
    output logic            o_busy,
    output logic [BITS-1:0] o_alu_argA,
    output logic [BITS-1:0] o_alu_argB,
    output logic [N-1:0]    o_alu_oper,
    input  logic [BITS-1:0] i_alu_result,
    input  logic [3:0]      i_alu_status
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

    state_t          state, state_nx;
    logic            ptr, ptr_nx;
    logic            win;
    logic [1:0]      ack_nx, gnt_nx;
    logic            busy_nx;
    logic [BITS-1:0] arg_a_nx, arg_b_nx, res0_nx, res1_nx;
    logic [N-1:0]    oper_nx;
    logic [3:0]      st0_nx, st1_nx;

    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            state      <= IDLE;
            ptr        <= 1'b0;
            o_ack      <= '0;
            o_gnt      <= '0;
            o_busy     <= 1'b0;
            o_alu_argA <= '0;
            o_alu_argB <= '0;
            o_alu_oper <= '0;
            o_result0  <= '0;
            o_result1  <= '0;
            o_status0  <= '0;
            o_status1  <= '0;
        end else begin
            state      <= state_nx;
            ptr        <= ptr_nx;
            o_ack      <= ack_nx;
            o_gnt      <= gnt_nx;
            o_busy     <= busy_nx;
            o_alu_argA <= arg_a_nx;
            o_alu_argB <= arg_b_nx;
            o_alu_oper <= oper_nx;
            o_result0  <= res0_nx;
            o_result1  <= res1_nx;
            o_status0  <= st0_nx;
            o_status1  <= st1_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        ack_nx   = '0;
        gnt_nx   = o_gnt;
        arg_a_nx = o_alu_argA;
        arg_b_nx = o_alu_argB;
        oper_nx  = o_alu_oper;
        res0_nx  = o_result0;
        res1_nx  = o_result1;
        st0_nx   = o_status0;
        st1_nx   = o_status1;

        // A lone request wins outright; the pointer only breaks ties.
        case (i_req)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            default: win = ptr;
        endcase

        case (state)
            IDLE: begin
                if (i_req != '0) begin
                    state_nx = ISSUE;
                    gnt_nx   = win ? 2'b10 : 2'b01;
                    arg_a_nx = win ? i_argA1 : i_argA0;
                    arg_b_nx = win ? i_argB1 : i_argB0;
                    oper_nx  = win ? i_oper1 : i_oper0;
                end
            end
            ISSUE: state_nx = CAPTURE;
            CAPTURE: begin
                state_nx = IDLE;
                gnt_nx   = '0;
                ack_nx   = o_gnt;
                ptr_nx   = ~o_gnt[1];
                if (o_gnt[1]) begin
                    res1_nx = i_alu_result;
                    st1_nx  = i_alu_status;
                end else begin
                    res0_nx = i_alu_result;
                    st0_nx  = i_alu_status;
                end
            end
            default: state_nx = IDLE;
        endcase

        busy_nx = (state_nx != IDLE);
    end

endmodule

// File: tb/tb_exe_unit_rr_sched.sv
// Bench for exe_unit_rr_sched: stub XOR ALU, transaction-level reference model,
// directed scenarios followed by randomized request/operand traffic.
module tb_exe_unit_rr_sched;

    localparam int BITS = 4;
    localparam int N    = 2;

    logic            clk = 1'b0;
    logic            rsn;
    logic [1:0]      req;
    logic [BITS-1:0] arg_a0, arg_b0, arg_a1, arg_b1;
    logic [N-1:0]    oper0, oper1;
    logic [1:0]      ack, gnt;
    logic [BITS-1:0] result0, result1, alu_arg_a, alu_arg_b, alu_result;
    logic [3:0]      status0, status1, alu_status;
    logic            busy;
    logic [N-1:0]    alu_oper;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    exe_unit_rr_sched #(.BITS(BITS), .N(N)) dut (
        .i_clk        (clk),
        .i_rsn        (rsn),
        .i_req        (req),
        .i_argA0      (arg_a0),
        .i_argB0      (arg_b0),
        .i_oper0      (oper0),
        .i_argA1      (arg_a1),
        .i_argB1      (arg_b1),
        .i_oper1      (oper1),
        .o_ack        (ack),
        .o_result0    (result0),
        .o_result1    (result1),
        .o_status0    (status0),
        .o_status1    (status1),
        .o_gnt        (gnt),
        .o_busy       (busy),
        .o_alu_argA   (alu_arg_a),
        .o_alu_argB   (alu_arg_b),
        .o_alu_oper   (alu_oper),
        .i_alu_result (alu_result),
        .i_alu_status (alu_status)
    );

    always #5 clk = ~clk;

    // Stub ALU: registered XOR with zero flag.
    always_ff @(posedge clk) begin
        alu_result <= alu_arg_a ^ alu_arg_b;
        alu_status <= {3'b000, (alu_arg_a ^ alu_arg_b) == '0};
    end

    // Reference model: a transaction in flight with a remaining-cycle count.
    int              m_cnt;
    int              m_owner;
    int              m_ptr;
    logic [1:0]      m_ack;
    logic [BITS-1:0] m_a, m_b;
    logic [N-1:0]    m_op;
    logic [BITS-1:0] m_res [2];
    logic [3:0]      m_st  [2];

    task automatic model_reset();
        m_cnt = 0; m_owner = 0; m_ptr = 0; m_ack = '0;
        m_a = '0; m_b = '0; m_op = '0;
        for (int k = 0; k < 2; k++) begin
            m_res[k] = '0;
            m_st[k]  = '0;
        end
    endtask

    task automatic model_step();
        logic [BITS-1:0] r;
        m_ack = '0;
        if (m_cnt == 0) begin
            if (req != 2'b00) begin
                if (req == 2'b11) m_owner = m_ptr;
                else              m_owner = req[1] ? 1 : 0;
                m_a  = m_owner == 1 ? arg_a1 : arg_a0;
                m_b  = m_owner == 1 ? arg_b1 : arg_b0;
                m_op = m_owner == 1 ? oper1  : oper0;
                m_cnt = 2;
            end
        end else if (m_cnt == 2) begin
            m_cnt = 1;
        end else begin
            r = m_a ^ m_b;
            m_res[m_owner] = r;
            m_st[m_owner]  = {3'b000, r == '0};
            m_ack[m_owner] = 1'b1;
            m_ptr = 1 - m_owner;
            m_cnt = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [1:0] e_gnt;
        e_gnt = (m_cnt == 0) ? 2'b00 : (m_owner == 1 ? 2'b10 : 2'b01);
        chk("ack",     32'(ack),       32'(m_ack));
        chk("gnt",     32'(gnt),       32'(e_gnt));
        chk("busy",    32'(busy),      32'(m_cnt != 0));
        chk("alu_a",   32'(alu_arg_a), 32'(m_a));
        chk("alu_b",   32'(alu_arg_b), 32'(m_b));
        chk("alu_op",  32'(alu_oper),  32'(m_op));
        chk("result0", 32'(result0),   32'(m_res[0]));
        chk("result1", 32'(result1),   32'(m_res[1]));
        chk("status0", 32'(status0),   32'(m_st[0]));
        chk("status1", 32'(status1),   32'(m_st[1]));
    endtask

    // Called at a negedge; returns at the following negedge after checking.
    task automatic cycle();
        @(posedge clk);
        if (rsn) model_step();
        else     model_reset();
        @(negedge clk);
        compare_all();
    endtask

    // Asynchronous reset pulse entirely between two rising edges.
    task automatic reset_pulse();
        #1 rsn = 1'b0;
        #1 model_reset();
        compare_all();
        #1 rsn = 1'b1;
    endtask

    task automatic set_ops(input logic [BITS-1:0] a0, b0, a1, b1);
        arg_a0 = a0; arg_b0 = b0; arg_a1 = a1; arg_b1 = b1;
    endtask

    int n_ack;
    int lat;

    initial begin
        rsn = 1'b0; req = 2'b11;
        set_ops(4'h5, 4'h3, 4'h6, 4'h1);
        oper0 = 2'b01; oper1 = 2'b10;
        model_reset();
        @(negedge clk);

        // Reset held with both requests pending, then async clear mid-operation.
        for (int i = 0; i < 3; i++) cycle();
        rsn = 1'b1;
        cycle();
        cycle();
        reset_pulse();
        req = 2'b00;
        cycle();

        // Single request from requester 0.
        set_ops(4'b0010, 4'b0001, 4'b0000, 4'b0000);
        oper0 = 2'b01;
        req = 2'b01;
        cycle();
        chk("single_gnt", 32'(gnt), 32'(2'b01));
        chk("single_op",  32'(alu_oper), 32'(2'b01));
        cycle();
        chk("single_busy2", 32'(busy), 32'(1'b1));
        cycle();
        chk("single_ack", 32'(ack), 32'(2'b01));
        chk("single_res0", 32'(result0), 32'(4'b0011));
        chk("single_st0",  32'(status0), 32'(4'b0000));
        chk("single_res1", 32'(result1), 32'(4'b0000));
        req = 2'b00;
        cycle();
        chk("single_ack_pulse", 32'(ack), 32'(2'b00));

        // Contention from reset.
        reset_pulse();
        set_ops(4'b0100, 4'b0100, 4'b1001, 4'b1000);
        req = 2'b11;
        for (int t = 0; t < 4; t++) begin
            cycle();
            cycle();
            cycle();
            chk("cont_ack", 32'(ack), (t % 2 == 0) ? 32'(2'b01) : 32'(2'b10));
            if (t == 0) begin
                chk("cont_res0", 32'(result0), 32'(4'b0000));
                chk("cont_st0",  32'(status0), 32'(4'b0001));
            end
            if (t == 1) chk("cont_res1", 32'(result1), 32'(4'b0001));
        end
        req = 2'b00;
        cycle();

        // Operand isolation after grant to requester 1.
        reset_pulse();
        set_ops(4'h0, 4'h0, 4'b1000, 4'b0000);
        req = 2'b10;
        cycle();
        arg_a1 = 4'b1111;
        cycle();
        cycle();
        chk("iso_ack",  32'(ack),     32'(2'b10));
        chk("iso_res1", 32'(result1), 32'(4'b1000));
        req = 2'b00;
        cycle();

        // Pointer persists across idle cycles.
        reset_pulse();
        req = 2'b01;
        for (int i = 0; i < 3; i++) cycle();
        req = 2'b00;
        for (int i = 0; i < 5; i++) cycle();
        req = 2'b11;
        cycle();
        chk("ptr_gnt", 32'(gnt), 32'(2'b10));
        cycle();
        cycle();
        req = 2'b00;
        cycle();

        // Reset during CAPTURE abandons the transaction.
        reset_pulse();
        req = 2'b10;
        cycle();
        cycle();
        reset_pulse();
        chk("rstmid_ack", 32'(ack), 32'(2'b00));
        n_ack = 0; lat = 0;
        for (int i = 1; i <= 4; i++) begin
            cycle();
            if (ack == 2'b10) begin
                n_ack++;
                lat = i;
            end
            if (i == 3) req = 2'b00;
        end
        chk("rstmid_ack_count", 32'(n_ack), 32'd1);
        chk("rstmid_ack_lat",   32'(lat),   32'd3);

        // Randomized traffic honouring the hold-until-ack protocol.
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!req[k])      req[k] = ($urandom_range(0, 2) == 0);
                else if (m_ack[k]) req[k] = ($urandom_range(0, 1) == 1);
            end
            arg_a0 = 4'($urandom); arg_b0 = 4'($urandom);
            arg_a1 = 4'($urandom); arg_b1 = 4'($urandom);
            oper0  = 2'($urandom); oper1  = 2'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                arg_a0 = arg_b0;
                arg_a1 = arg_b1;
            end
            if ($urandom_range(0, 63) == 0) reset_pulse();
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/exe_unit_rr_sched.md
# exe_unit_rr_sched

Round-robin scheduler that shares one registered execution unit (ALU, `BITS`-wide operands, `N`-bit operation select, 4-bit status) between two requesters. The block sits between two operand sources (for example, two APB-side register banks) and a single ALU instance. It grants the ALU to one requester at a time, drives the ALU operand and operation inputs from registers, captures the ALU result and status one cycle later, and returns them to the winning requester with a one-cycle acknowledge pulse.

## Interface
- `BITS`, 4, operand/result width
- `N`, 2, operation-select width

- `i_clk` in 1: single clock, all state updates on its rising edge.
- `i_rsn` in 1: reset, asynchronous, active-low.
- `i_req` in 2: request, bit k belongs to requester k. It is held high until `o_ack[k]`.
- `i_argA0`, `i_argB0` in BITS: requester 0 operands.
- `i_oper0` in N: requester 0 operation.
- `i_argA1`, `i_argB1` in BITS: requester 1 operands.
- `i_oper1` in N: requester 1 operation.
- `o_ack` out 2: one-cycle pulse, bit k set when `o_result`/`o_status` for requester k are valid.
- `o_result0`, `o_result1` out BITS: captured result per requester, held until the next ack to the same requester.
- `o_status0`, `o_status1` out 4: captured status per requester, held the same way.
- `o_gnt` out 2: one-hot owner of the ALU while busy, 00 when idle.
- `o_busy` out 1: high in states ISSUE and CAPTURE.
- `o_alu_argA`, `o_alu_argB` out BITS: registered ALU operands.
- `o_alu_oper` out N: registered ALU operation.
- `i_alu_result` in BITS: ALU result, registered inside the ALU (valid one cycle after its inputs are sampled).
- `i_alu_status` in 4: ALU status, same timing as `i_alu_result`.

## Operation
FSM states are IDLE, ISSUE and CAPTURE. Reset enters IDLE.

IDLE:
- If `i_req` is 00, stay in IDLE.
- If exactly one bit is set, grant that requester.
- If both bits are set, grant the requester selected by the priority pointer `ptr` (reset 0).
- On grant:
  - register the winner's argA, argB and oper into `o_alu_*`;
  - set `o_gnt` one-hot;
  - go to ISSUE.

ISSUE:
- `o_alu_*` are stable, and the ALU samples them at the end of this cycle.
- Go to CAPTURE unconditionally.

CAPTURE:
- `i_alu_result`/`i_alu_status` are valid.
- At the end of this cycle:
  - latch them into the granted requester's `o_result`/`o_status`;
  - set `o_ack[g]`;
  - set `ptr` to the other requester;
  - clear `o_gnt`;
  - go to IDLE.

Other rules:
- Operands are latched only at grant. Requester input changes during ISSUE and CAPTURE have no effect.
- If `i_req[k]` is still high in the cycle `o_ack[k]` is high, it is a new back-to-back request and is arbitrated normally in that IDLE cycle.
- The non-granted requester's outputs never change.
- `ptr` changes only on completion. It does not change on grant or while idle.
- Reset mid-operation: the transaction is abandoned, no ack is issued, and the requester must re-request.

## Timing
- Reset values:
  - state IDLE, `ptr` 0;
  - `o_ack` 00, `o_gnt` 00, `o_busy` 0;
  - `o_alu_argA`/`o_alu_argB`/`o_alu_oper` 0;
  - `o_result0`/`o_result1` 0, `o_status0`/`o_status1` 0.
- All outputs are registered. No combinational path runs from `i_req` or `i_alu_*` to any output.
- Latency: `i_req` sampled high at edge E0 gives `o_gnt`/`o_busy` from E0, ALU inputs valid E0–E2, ALU result valid E1–E2, and `o_ack` plus data from E2 (3 cycles).
- `o_ack` is high for exactly one cycle, coincident with IDLE.
- Throughput: one operation per 3 cycles under continuous requests.
- Fairness: with both requests held continuously, grants alternate 0,1,0,1…
- Maximum wait for a requester: one foreign operation (3 cycles) plus its own operation.

## Test plan
The bench uses a stub ALU: on each clock edge it registers result = argA ^ argB and status = {3'b000, result==0}.

1. **Reset values**: with `i_rsn`=0 and `i_req`=11 driven, every output stays at its reset value. Asserting `i_rsn`=0 asynchronously mid-clock clears all outputs immediately.
2. **Single request**: `i_req`=01, A0=0010, B0=0001, oper0=01.
   - `o_gnt`=01 and `o_busy`=1 for 2 cycles.
   - `o_alu_oper`=01.
   - `o_ack`=01 for exactly 1 cycle, 3 cycles after request sampling.
   - `o_result0`=0011, `o_status0`=0000.
   - `o_result1` stays 0000.
3. **Contention from reset**: `i_req`=11 held, A0=B0=0100, A1=1001, B1=1000.
   - First ack is 01 with `o_result0`=0000 and `o_status0`=0001.
   - Next ack is 10 with `o_result1`=0001.
   - Acks continue alternating 01,10,01… every 3 cycles.
4. **Operand isolation**: after the grant to requester 1 with A1=1000, B1=0000, change A1 to 1111 during ISSUE. The bench still receives `o_result1`=1000.
5. **Pointer persistence**: complete one op for requester 0, idle 5 cycles, then raise `i_req`=11. Requester 1 wins first.
6. **Reset mid-operation**: pulse `i_rsn` low during CAPTURE.
   - No ack appears, and the state is IDLE with `ptr`=0.
   - Keeping `i_req`=10 restarts a full 3-cycle transaction and produces a single ack of 10.
